// File: rtl/output_interface_if.sv
// rtl/output_interface_if.sv - router output port bus: upstream requests/flits/clears and downstream so/ro/datao
interface output_interface_if #(
  parameter int DATA_WIDTH = 64
);
  logic [4:0]              req_in;
  logic [5*DATA_WIDTH-1:0] data_in;
  logic [4:0]              buf_clear;
  logic                    so;
  logic                    ro;
  logic [DATA_WIDTH-1:0]   datao;

  modport slave (
    input  req_in,
    input  data_in,
    input  ro,
    output buf_clear,
    output so,
    output datao
  );

  modport master (
    output req_in,
    output data_in,
    output ro,
    input  buf_clear,
    input  so,
    input  datao
  );
endinterface

// File: rtl/output_interface.sv
// rtl/output_interface.sv - round-robin router output port with 1-entry slot; OUT_IF_PKT_CNT_EN adds pkt_cnt
module output_interface #(
  parameter int         DATA_WIDTH = 64,
  parameter logic [4:0] DIRECTION  = 5'b00001
) (
  input  logic                clk,
  input  logic                rst,
  output_interface_if.slave   bus,
  output logic [4:0]          grant_dbg
`ifdef OUT_IF_PKT_CNT_EN
  ,
  output logic [15:0]         pkt_cnt
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                state, state_nxt;
  logic [4:0]            eff_req, grant;
  logic [2:0]            rr_idx, grant_idx;
  logic [3:0]            cand;
  logic                  found, full, xfer, load;
  logic [DATA_WIDTH-1:0] sel_flit;

  // No U-turn: a flit never leaves through the port it arrived on.
  assign eff_req = bus.req_in & ~DIRECTION;
  assign full    = (state == FULL);
  assign xfer    = full & bus.ro;
  // Gated by rst so no input is told its flit was consumed while in reset.
  assign load    = rst & (|eff_req) & (!full | xfer);

  always_comb begin
    grant     = '0;
    grant_idx = 3'd0;
    cand      = 4'd0;
    found     = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cand = {1'b0, rr_idx} + 4'(k);
      if (cand >= 4'd5) cand = cand - 4'd5;
      if (!found && eff_req[cand[2:0]]) begin
        found            = 1'b1;
        grant_idx        = cand[2:0];
        grant[cand[2:0]] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_flit = '0;
    for (int i = 0; i < 5; i++) begin
      if (grant_idx == 3'(i)) sel_flit = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (xfer && !load) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  assign bus.so        = full;
  assign bus.buf_clear = load ? grant : 5'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_idx    <= 3'd4;
      bus.datao <= '0;
      grant_dbg <= '0;
    end else if (load) begin
      rr_idx    <= grant_idx;
      bus.datao <= sel_flit;
      grant_dbg <= grant;
    end else if (xfer) begin
      grant_dbg <= '0;
    end
  end

`ifdef OUT_IF_PKT_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      pkt_cnt <= 16'd0;
    else if (xfer) pkt_cnt <= pkt_cnt + 16'd1;
  end
`endif

endmodule
